// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and default widths for the serial pattern generator
package seq_gen_pkg;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_REP_W = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_e;
endpackage

// File: rtl/seq_piso_shift.sv
// seq_piso_shift: parallel-load, MSB-first shift register with load/shift enables
module seq_piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         dout_o
);
  logic [W-1:0] sr_q;
  // load has priority over shift; zeros fill in from the LSB side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr_q <= '0;
    else if (load_i) sr_q <= din_i;
    else if (shift_i) sr_q <= {sr_q[W-2:0], 1'b0};
  end
  assign dout_o = sr_q[W-1];
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: repeating MSB-first serial pattern generator; SEQ_GEN_PARITY_EN appends an even-parity bit per frame
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(PAT_W + 2);
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] frm_q, frm_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift;
  logic [PAT_W-1:0] load_val;
  logic             sr_msb;
  logic             tail_bit;
  // the shift register holds the bits still to be sent after the one on out_bit
  seq_piso_shift #(.W(PAT_W)) u_piso (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .shift_i(shift),
    .din_i  (load_val),
    .dout_o (sr_msb)
  );
`ifdef SEQ_GEN_PARITY_EN
  localparam int FRAME_LEN = PAT_W + 1;
  assign tail_bit = (bit_q == BW'(PAT_W - 1)) ? ^pat_q : sr_msb;
`else
  localparam int FRAME_LEN = PAT_W;
  assign tail_bit = sr_msb;
`endif
  localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);
  // next state and next registered outputs; outputs reflect the state being entered
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    frm_d       = frm_q;
    bit_d       = bit_q;
    load        = 1'b0;
    shift       = 1'b0;
    load_val    = {pat_q[PAT_W-2:0], 1'b0};
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d     = SHIFT;
        pat_d       = pattern;
        frm_d       = repeat_cnt;
        bit_d       = '0;
        load        = 1'b1;
        load_val    = {pattern[PAT_W-2:0], 1'b0};
        out_bit_d   = pattern[PAT_W-1];
        out_valid_d = 1'b1;
      end
      SHIFT: if (abort) state_d = IDLE;
      else if (bit_q == LAST) begin
        bit_d   = '0;
        state_d = (frm_q == '0) ? DONE : GAP;
        done_d  = (frm_q == '0);
        frm_d   = (frm_q == '0) ? frm_q : frm_q - 1'b1;
      end else begin
        bit_d       = bit_q + 1'b1;
        shift       = 1'b1;
        out_bit_d   = tail_bit;
        out_valid_d = 1'b1;
      end
      GAP: if (abort) state_d = IDLE;
      else begin
        state_d     = SHIFT;
        load        = 1'b1;
        out_bit_d   = pat_q[PAT_W-1];
        out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  // state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      frm_q       <= '0;
      bit_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      frm_q       <= frm_d;
      bit_q       <= bit_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 8, giving the pattern width in bits (legal range 2..32).
REQ-002 SHALL have parameter REP_W, default 4, giving the repeat-count width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin transmission, sampled in IDLE only.
REQ-006 SHALL have port pattern, input, PAT_W bits: the serial pattern, sent MSB first.
REQ-007 SHALL have port repeat_cnt, input, REP_W bits: number of extra frames (total frames = repeat_cnt+1).
REQ-008 SHALL have port abort, input, 1 bit: terminates any transmission in progress.
REQ-009 SHALL have port out_bit, output, 1 bit: serial data, registered.
REQ-010 SHALL have port out_valid, output, 1 bit: high when out_bit carries a pattern or parity bit, registered.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE, registered.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse on normal completion, registered.

Function
REQ-013 SHALL implement states IDLE, SHIFT, GAP and DONE.
REQ-014 SHALL, in IDLE with start=1 and abort=0, latch pattern and repeat_cnt and enter SHIFT on the next edge, with out_bit=pattern[PAT_W-1] and out_valid=1 in that same cycle.
REQ-015 SHALL, in SHIFT, present one bit per cycle MSB first, so that a frame occupies PAT_W consecutive valid cycles (PAT_W+1 when parity is enabled).
REQ-016 SHALL, after the last bit of a frame, enter GAP for exactly one cycle (out_valid=0, out_bit=0) when frames remain, then re-enter SHIFT from the latched MSB.
REQ-017 SHALL, after the last bit of the final frame, enter DONE for one cycle (done=1, out_valid=0, busy=1) and then return to IDLE.
REQ-018 SHALL ignore changes to pattern and repeat_cnt after they are latched, and SHALL ignore start in any state other than IDLE.
REQ-019 SHALL, on abort=1 in SHIFT, GAP or DONE, enter IDLE on the next edge with out_valid=0, busy=0 and done=0; in DONE, abort suppresses nothing already driven in that cycle.
REQ-020 SHALL give abort priority over start when both are high in IDLE (the block stays in IDLE).
REQ-021 SHALL decrement the frame counter once per completed frame; the counter SHALL NOT wrap, and repeat_cnt=0 SHALL yield exactly one frame.
REQ-022 SHALL accept start again in the IDLE cycle that immediately follows DONE (back-to-back runs allowed).

Reset
REQ-023 SHALL, while reset=0, asynchronously force state=IDLE, out_bit=0, out_valid=0, busy=0, done=0, and clear the counters and shift register.
REQ-024 SHALL, on reset mid-frame, drop the frame with no done pulse and wait in IDLE for a new start.

Configuration
REQ-025 SHALL, when SEQ_GEN_PARITY_EN is defined, append one even-parity bit (XOR of the latched pattern) with out_valid=1 after the LSB of each frame; without the macro, frames SHALL be PAT_W bits with no parity logic.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the default widths in shared package seq_gen_pkg.
REQ-027 SHALL instantiate one sub-module, seq_piso_shift (parallel-load, MSB-first shift register with load/shift enables); counters and the FSM SHALL stay in the top module.

Verification
REQ-028 SHALL test single frame, parity off: pattern=8'hB2, repeat_cnt=0, start pulse -> out_bit 1,0,1,1,0,0,1,0 with out_valid=1 over cycles 1-8, done=1 at cycle 9, busy=0 at cycle 10.
REQ-029 SHALL test repeats: pattern=8'hB2, repeat_cnt=2 -> three frames separated by single GAP cycles, 26 busy transmit cycles, done at cycle 27.
REQ-030 SHALL test abort: abort=1 during the 4th bit -> next cycle out_valid=0, busy=0, no done pulse; a new start is then accepted normally.
REQ-031 SHALL test start while busy and pattern changes mid-frame: start pulse and pattern=8'hFF at cycle 3 of an 8'hB2 frame -> transmitted bits unchanged and exactly one done pulse.
REQ-032 SHALL test asynchronous reset: reset=0 between edges during cycle 5 -> all outputs 0 immediately, IDLE after release, no done pulse.
REQ-033 SHALL test parity, with SEQ_GEN_PARITY_EN defined: pattern=8'hB3 -> nine valid bits ending with parity 1, done at cycle 10.
